// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the debug/loader port.
// Each access: grant in IDLE, WAIT_STATES+1 ACCESS cycles, then a one-cycle ack in DONE.
module mem_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          win;

   // owner doubles as last_grant: on a tie the port that did not win last time goes next
   assign win = (cpu_req && dbg_req) ? ~owner : dbg_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         owner     <= 1'b1;
         busy      <= 1'b0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || dbg_req) begin
                  state     <= ACCESS;
                  busy      <= 1'b1;
                  owner     <= win;
                  cnt       <= '0;
                  mem_en    <= 1'b1;
                  mem_we    <= win ? dbg_we    : cpu_we;
                  mem_addr  <= win ? dbg_addr  : cpu_addr;
                  mem_wdata <= win ? dbg_wdata : cpu_wdata;
               end
            end
            ACCESS: begin
               if (cnt == LAST) begin
                  state  <= DONE;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (owner) begin
                     dbg_ack <= 1'b1;
                     if (!mem_we) dbg_rdata <= mem_rdata;
                  end else begin
                     cpu_ack <= 1'b1;
                     if (!mem_we) cpu_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboard of expected acks (port, cycle, read data) checked on the falling edge.
// A second instance with WAIT_STATES=0 covers the zero-wait sequencing.
module tb_mem_port_arbiter;

   localparam int W = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;

   logic        b_cpu_req, b_dbg_req;
   logic [15:0] b_cpu_addr, b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_cpu_ack, b_dbg_ack, b_mem_en, b_mem_we, b_busy, b_owner;

   logic [15:0] mem     [0:255];
   logic [15:0] ref_mem [0:255];

   typedef struct {
      logic        port;
      logic        rd;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [15:0] m_cpu_rdata, m_dbg_rdata;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(b_cpu_addr), .cpu_wdata(16'h0000),
      .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
      .dbg_req(b_dbg_req), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
      .dbg_rdata(b_dbg_rdata), .dbg_ack(b_dbg_ack),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
   );

   // Memory model: combinational read, write on every enabled write cycle
   assign mem_rdata   = mem[mem_addr[7:0]];
   assign b_mem_rdata = mem[b_mem_addr[7:0]];
   always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (cpu_ack || dbg_ack)) begin
         chk("dual_ack", {31'b0, cpu_ack & dbg_ack}, 32'd0);
         chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack_port", {31'b0, dbg_ack}, {31'b0, e.port});
            chk("ack_cyc", cyc, e.cyc);
            if (e.rd) begin
               if (e.port) m_dbg_rdata = e.data;
               else        m_cpu_rdata = e.data;
            end
            chk("cpu_rdata", {16'b0, cpu_rdata}, {16'b0, m_cpu_rdata});
            chk("dbg_rdata", {16'b0, dbg_rdata}, {16'b0, m_dbg_rdata});
         end
      end
   end

   // One access from an idle arbiter with no contention; returns at the negedge of the ack cycle
   task automatic access(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wd);
      exp_t x;
      bit   got;
      got = 1'b0;
      @(negedge clk);
      x.port = port;
      x.rd   = ~we;
      x.data = ref_mem[addr[7:0]];
      x.cyc  = cyc + W + 2;
      if (we) ref_mem[addr[7:0]] = wd;
      sb.push_back(x);
      if (port) begin
         dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
      end else begin
         cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = port ? dbg_ack : cpu_ack;
      end
      chk("ack_seen", {31'b0, got}, 32'd1);
      if (port) dbg_req = 1'b0;
      else      cpu_req = 1'b0;
   endtask

   initial begin
      int t0;
      exp_t x;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'h1000 + 16'(i * 3);
         ref_mem[i] = 16'h1000 + 16'(i * 3);
      end
      mem[16'h10]     = 16'hBEEF;
      ref_mem[16'h10] = 16'hBEEF;
      m_cpu_rdata = '0;
      m_dbg_rdata = '0;
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030; cpu_wdata = '0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0040; dbg_wdata = '0;
      b_cpu_req = 1'b0; b_dbg_req = 1'b0; b_cpu_addr = '0;
      repeat (3) @(negedge clk);

      // Reset state with both requests asserted
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_acks", {30'b0, cpu_ack, dbg_ack}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_owner", {31'b0, owner}, 32'd1);
      chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
      chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);

      // Both held high from reset release: strict alternation CPU, dbg, CPU, dbg
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         x.port = k[0];
         x.rd   = 1'b1;
         x.data = k[0] ? ref_mem[16'h40] : ref_mem[16'h30];
         x.cyc  = t0 + 3 + 4 * k;
         sb.push_back(x);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("arb_owner0", {31'b0, owner}, 32'd0);
      repeat (4) @(negedge clk);
      chk("arb_owner1", {31'b0, owner}, 32'd1);
      repeat (10) @(negedge clk);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("arb_idle", {31'b0, busy}, 32'd0);

      // CPU read of 0x0010 with mem_en/mem_addr sequencing
      fork
         access(1'b0, 1'b0, 16'h0010, 16'h0000);
         begin
            @(negedge clk);
            for (int k = 1; k <= W + 1; k++) begin
               @(negedge clk);
               chk("rd_mem_en", {31'b0, mem_en}, 32'd1);
               chk("rd_mem_addr", {16'b0, mem_addr}, 32'h0010);
            end
            @(negedge clk);
            chk("rd_mem_en_off", {31'b0, mem_en}, 32'd0);
         end
      join

      // Debug write while the CPU address wiggles
      fork
         access(1'b1, 1'b1, 16'h0020, 16'h1234);
         begin
            @(negedge clk);
            for (int k = 1; k <= W + 1; k++) begin
               @(negedge clk);
               cpu_addr = 16'h5555 + 16'(k);
               chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
               chk("wr_mem_addr", {16'b0, mem_addr}, 32'h0020);
               chk("wr_mem_wdata", {16'b0, mem_wdata}, 32'h1234);
            end
         end
      join

      // CPU changes its own address after grant: latched value is used
      fork
         access(1'b0, 1'b0, 16'h0030, 16'h0000);
         begin
            @(negedge clk);
            @(negedge clk);
            cpu_addr = 16'h0050;
            @(negedge clk);
            chk("latch_addr", {16'b0, mem_addr}, 32'h0030);
         end
      join
      access(1'b0, 1'b0, 16'h0020, 16'h0000);
      access(1'b1, 1'b0, 16'h0010, 16'h0000);

      // Reset pulsed mid-access: mem_en drops without a clock, no ack follows
      @(negedge clk);
      cpu_addr = 16'h0040; cpu_we = 1'b0; cpu_req = 1'b1;
      @(negedge clk);
      chk("mid_mem_en", {31'b0, mem_en}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_mem_en", {31'b0, mem_en}, 32'd0);
      chk("async_busy", {31'b0, busy}, 32'd0);
      chk("async_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
      m_cpu_rdata = '0;
      m_dbg_rdata = '0;
      cpu_req = 1'b0;
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_owner", {31'b0, owner}, 32'd1);
      chk("post_rst_idle", {31'b0, busy}, 32'd0);
      access(1'b0, 1'b0, 16'h0040, 16'h0000);

      // Zero wait states: ack at cycle 2, held request re-arbitrated, next ack at cycle 5
      @(negedge clk);
      b_cpu_addr = 16'h0010;
      b_cpu_req  = 1'b1;
      @(negedge clk);
      chk("w0_mem_en", {31'b0, b_mem_en}, 32'd1);
      @(negedge clk);
      chk("w0_ack1", {31'b0, b_cpu_ack}, 32'd1);
      chk("w0_rdata1", {16'b0, b_cpu_rdata}, 32'h0000BEEF);
      chk("w0_mem_en_off", {31'b0, b_mem_en}, 32'd0);
      b_cpu_addr = 16'h0030;
      @(negedge clk);
      chk("w0_ack_pulse", {31'b0, b_cpu_ack}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("w0_ack2", {31'b0, b_cpu_ack}, 32'd1);
      chk("w0_rdata2", {16'b0, b_cpu_rdata}, {16'b0, ref_mem[16'h30]});
      chk("w0_dbg_rdata", {16'b0, b_dbg_rdata}, 32'd0);
      b_cpu_req = 1'b0;
      repeat (3) @(negedge clk);

      chk("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
